// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Program buffer and instruction source for the multicycle control unit.
// Software loads a short program one 8-bit word per cycle while IDLE. A run
// pulse then streams the program to the CPU, one word per fetch request, using
// a request/valid handshake with a fixed one-cycle latency. Streaming stops on
// a HALT word (bits[7:4] == 4'b1111) or when the end of the program is reached.
//
// Ports:
//   clock_pulse  in   1          clock, all state changes on the rising edge
//   reset        in   1          synchronous, active-high reset
//   load_en      in   1          append load_data to the program (IDLE only)
//   load_data    in   8          instruction word to store
//   clear_prog   in   1          discard the loaded program (IDLE or HALT)
//   run          in   1          single-cycle start pulse
//   instr_req    in   1          CPU fetch request, one cycle per instruction
//   instr        out  8          last delivered instruction (held)
//   instr_valid  out  1          one-cycle pulse when instr carries a new word
//   pc           out  ADDR_W     index of the next word to deliver
//   count        out  ADDR_W+1   number of loaded words (0..DEPTH)
//   full         out  1          count == DEPTH
//   state        out  2          IDLE=00, RUN=01, HALT=10
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock_pulse,
  input  logic              reset,
  input  logic              load_en,
  input  logic [7:0]        load_data,
  input  logic              clear_prog,
  input  logic              run,
  input  logic              instr_req,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  state_t      cur_state;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  cur_word;
  logic        pc_in_prog;
  logic        cur_is_halt;
  logic        do_load;

  assign state       = cur_state;
  assign full        = (count == COUNT_FULL);
  assign cur_word    = mem[pc];
  assign pc_in_prog  = ({1'b0, pc} < count);
  assign cur_is_halt = (cur_word[7:4] == 4'b1111);

  // A load only lands in IDLE, with room left, and loses to clear_prog and
  // reset. The same qualifier drives both the buffer write and the count bump.
  assign do_load = !reset && (cur_state == IDLE) && !clear_prog && load_en && !full;

  // Program buffer. It has no reset: its contents are meaningless until
  // count says a slot has been written.
  always_ff @(posedge clock_pulse) begin
    if (do_load) begin
      mem[count[ADDR_W-1:0]] <= load_data;
    end
  end

  // Control FSM with registered outputs. instr_valid defaults low each cycle
  // so that it can only ever be a single-cycle pulse per delivered word.
  always_ff @(posedge clock_pulse) begin
    if (reset) begin
      cur_state   <= IDLE;
      pc          <= '0;
      count       <= '0;
      instr       <= 8'h00;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (cur_state)
        IDLE: begin
          // clear beats load, and any load attempt (even a dropped one on a
          // full buffer) suppresses a same-cycle run
          if (clear_prog) begin
            count <= '0;
          end else if (load_en) begin
            if (!full) begin
              count <= count + COUNT_ONE;
            end
          end else if (run && (count != '0)) begin
            cur_state <= RUN;
            pc        <= '0;
          end
        end
        RUN: begin
          if (instr_req) begin
            if (pc_in_prog && !cur_is_halt) begin
              instr       <= cur_word;
              instr_valid <= 1'b1;
              pc          <= pc + PC_ONE;
            end else begin
              // pc is left on the HALT word (or at end of program)
              cur_state <= HALT;
            end
          end
        end
        HALT: begin
          if (clear_prog) begin
            count     <= '0;
            pc        <= '0;
            cur_state <= IDLE;
          end else if (run) begin
            pc        <= '0;
            cur_state <= RUN;
          end
        end
        default: begin
          cur_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed self-checking bench for instr_sequencer. Inputs are driven on the
// falling edge, held for exactly one rising edge, and outputs are sampled on
// the following falling edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  logic       clock_pulse;
  logic       reset;
  logic       load_en;
  logic [7:0] load_data;
  logic       clear_prog;
  logic       run;
  logic       instr_req;
  logic [7:0] instr;
  logic       instr_valid;
  logic [3:0] pc;
  logic [4:0] count;
  logic       full;
  logic [1:0] state;

  int total_checks;
  int bad_checks;

  logic [7:0] full_words [16];
  logic [7:0] b2b_words [4];

  instr_sequencer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clock_pulse (clock_pulse),
    .reset       (reset),
    .load_en     (load_en),
    .load_data   (load_data),
    .clear_prog  (clear_prog),
    .run         (run),
    .instr_req   (instr_req),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .count       (count),
    .full        (full),
    .state       (state)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock_pulse = 1'b0;
    forever #5 clock_pulse = ~clock_pulse;
  end

  // Drive one cycle of inputs across a single rising edge, then return on the
  // falling edge with all inputs released back to zero.
  task automatic applyStimulus(input logic rst, input logic le, input logic [7:0] ld,
                               input logic cp, input logic rn, input logic rq);
    reset      = rst;
    load_en    = le;
    load_data  = ld;
    clear_prog = cp;
    run        = rn;
    instr_req  = rq;
    @(posedge clock_pulse);
    @(negedge clock_pulse);
    reset      = 1'b0;
    load_en    = 1'b0;
    clear_prog = 1'b0;
    run        = 1'b0;
    instr_req  = 1'b0;
  endtask

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    reset      = 1'b1;
    load_en    = 1'b0;
    load_data  = 8'h00;
    clear_prog = 1'b0;
    run        = 1'b0;
    instr_req  = 1'b0;

    for (int i = 0; i < 13; i++) full_words[i + 3] = 8'h40 + 8'(i);
    full_words[0]  = 8'h12;
    full_words[1]  = 8'h1A;
    full_words[2]  = 8'h36;
    full_words[15] = 8'h5C;
    b2b_words[0] = 8'h01;
    b2b_words[1] = 8'h23;
    b2b_words[2] = 8'h45;
    b2b_words[3] = 8'h67;

    repeat (2) @(posedge clock_pulse);
    @(negedge clock_pulse);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_state", state, 2'b00);
    checkOutput("rst_pc", pc, 4'd0);
    checkOutput("rst_count", count, 5'd0);
    checkOutput("rst_instr", instr, 8'h00);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_full", full, 1'b0);

    $display("[TB] load and full");
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, full_words[i], 0, 0, 0);
    checkOutput("ld3_count", count, 5'd3);
    checkOutput("ld3_full", full, 1'b0);
    for (int i = 3; i < 16; i++) applyStimulus(0, 1, full_words[i], 0, 0, 0);
    checkOutput("ld16_count", count, 5'd16);
    checkOutput("ld16_full", full, 1'b1);
    applyStimulus(0, 1, 8'hAA, 0, 0, 0);
    checkOutput("ld17_count", count, 5'd16);
    checkOutput("ld17_state", state, 2'b00);
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    checkOutput("full_run_state", state, 2'b01);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 1);
      checkOutput($sformatf("full_w%0d", i), instr, full_words[i]);
      checkOutput($sformatf("full_v%0d", i), instr_valid, 1'b1);
    end
    applyStimulus(1, 0, 8'h00, 0, 0, 0);

    $display("[TB] basic run and replay");
    applyStimulus(0, 1, 8'h12, 0, 0, 0);
    applyStimulus(0, 1, 8'h36, 0, 0, 0);
    applyStimulus(0, 1, 8'hF0, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 1);
    checkOutput("run_state", state, 2'b01);
    checkOutput("run_pc", pc, 4'd0);
    checkOutput("run_req_ignored", instr_valid, 1'b0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("r1_instr", instr, 8'h12);
    checkOutput("r1_valid", instr_valid, 1'b1);
    checkOutput("r1_pc", pc, 4'd1);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    checkOutput("gap_valid", instr_valid, 1'b0);
    checkOutput("gap_instr_hold", instr, 8'h12);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("r2_instr", instr, 8'h36);
    checkOutput("r2_valid", instr_valid, 1'b1);
    checkOutput("r2_pc", pc, 4'd2);
    applyStimulus(0, 0, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("r3_valid", instr_valid, 1'b0);
    checkOutput("r3_state", state, 2'b10);
    checkOutput("r3_pc", pc, 4'd2);
    checkOutput("r3_instr_hold", instr, 8'h36);
    applyStimulus(0, 1, 8'h77, 0, 0, 1);
    checkOutput("halt_load_ignored", count, 5'd3);
    checkOutput("halt_req_ignored", instr_valid, 1'b0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    checkOutput("replay_state", state, 2'b01);
    checkOutput("replay_pc", pc, 4'd0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("replay_instr", instr, 8'h12);
    checkOutput("replay_valid", instr_valid, 1'b1);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("rehalt_state", state, 2'b10);
    applyStimulus(0, 0, 8'h00, 1, 1, 0);
    checkOutput("clr_state", state, 2'b00);
    checkOutput("clr_count", count, 5'd0);
    checkOutput("clr_pc", pc, 4'd0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    checkOutput("empty_run_state", state, 2'b00);

    $display("[TB] end of program");
    applyStimulus(0, 1, 8'h12, 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("eop_instr", instr, 8'h12);
    checkOutput("eop_valid", instr_valid, 1'b1);
    applyStimulus(0, 0, 8'h00, 0, 0, 1);
    checkOutput("eop_end_valid", instr_valid, 1'b0);
    checkOutput("eop_end_state", state, 2'b10);
    checkOutput("eop_end_pc", pc, 4'd1);
    applyStimulus(0, 0, 8'h00, 1, 0, 0);
    checkOutput("eop_clr_state", state, 2'b00);

    $display("[TB] back-to-back fetch");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, b2b_words[i], 0, 0, 0);
    applyStimulus(0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 8'h00, 0, 0, 1);
      checkOutput($sformatf("b2b_w%0d", i), instr, b2b_words[i]);
      checkOutput($sformatf("b2b_v%0d", i), instr_valid, 1'b1);
    end
    checkOutput("b2b_pc", pc, 4'd4);
    checkOutput("b2b_state", state, 2'b01);

    $display("[TB] reset mid-run");
    applyStimulus(1, 0, 8'h00, 0, 0, 1);
    checkOutput("mid_rst_state", state, 2'b00);
    checkOutput("mid_rst_instr", instr, 8'h00);
    checkOutput("mid_rst_valid", instr_valid, 1'b0);
    checkOutput("mid_rst_pc", pc, 4'd0);
    checkOutput("mid_rst_count", count, 5'd0);
    applyStimulus(0, 1, 8'h11, 0, 1, 0);
    checkOutput("ldrun_count", count, 5'd1);
    checkOutput("ldrun_state", state, 2'b00);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
